alu_lane_writeback: RTL and testbench
=====================================

Name: alu_lane_writeback

Overview:
- Consumer end of the 6-lane vector ALU datapath: accepts one packed 6-lane result vector plus per-lane flags through a valid/ready handshake.
- Serialises the enabled lanes into a byte-wide data-memory write port, one lane per accepted memory cycle, at base_addr + lane index.
- Sits between the execute/writeback stage and data memory; it is the path for vector results bound for memory (e.g. RSA block outputs).

Parameters:
- N, 8, lane width and memory data width in bits
- A, 8, memory address width in bits

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  result vector offered
- in_ready  output  1  block can capture a vector this cycle
- lanes  input  [5:0][N-1:0]  ALU lane results; lane 0 in the low slice
- lane_flags  input  [5:0][1:0]  per-lane ALU flags
- lane_mask  input  6  1 = write that lane, 0 = skip it
- base_addr  input  A  address of lane 0
- mem_we  output  1  write request
- mem_addr  output  A  write address
- mem_wdata  output  N  write data
- mem_ready  input  1  memory accepts the write this cycle
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse at the end of each vector
- sticky_flags  output  2  OR of the flags of all written lanes (optional feature)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: state IDLE; mem_we, mem_addr, mem_wdata, done, busy and sticky_flags all 0. In IDLE, in_ready = 1 combinationally.
- FSM states: IDLE, SEND, DONE.
- IDLE: capture happens on in_valid && in_ready. The capture registers lanes, lane_flags, lane_mask and base_addr; later input changes are ignored. After capture the state becomes SEND if the mask is nonzero, otherwise DONE.
- SEND: cur = lowest set bit of the remaining mask. Outputs are registered: mem_we = 1, mem_addr = base_addr + cur (modulo 2^A, wrap permitted), mem_wdata = lanes[cur].
  - A write handshake is mem_we && mem_ready. On a handshake, clear bit cur from the remaining mask and present the next set lane in the next cycle.
  - A handshake on the last set lane moves the state to DONE and drops mem_we in the next cycle.
  - While mem_ready = 0, mem_addr, mem_wdata and mem_we hold stable.
- DONE: exactly one cycle; done = 1, in_ready = 0, then back to IDLE. There is no back-to-back capture during DONE.
- Latency with mem_ready held high: capture at edge k; first write in cycle k+1; popcount(mask) write cycles; done in the following cycle; in_ready high again in the cycle after that.
- Lanes are always written in ascending index order. Skipped lanes leave address holes; addresses are never compacted.
- A write is never issued for a masked-off lane.
- busy = (state != IDLE).
- Reset asserted mid-SEND aborts the transfer immediately. Remaining lanes are never written, and no done pulse is produced.

Optional Feature:
- Macro: ALU_WB_STICKY_FLAGS_EN.
- Defined:
  - sticky_flags |= lane_flags[cur] on every write handshake.
  - Cleared to 0 on each new capture and on reset.
  - Holds its value after DONE until the next capture.
- Undefined: sticky_flags tied to 0 and no flag storage is synthesised. The captured lane_flags may be optimised away.

Decomposition:
- Package alu_wb_pkg holds:
  - constant NLANES = 6
  - typedef wb_state_t {IDLE, SEND, DONE}
  - typedef lane_idx_t (3 bits)
- Sub-module lane_pick: combinational lowest-set-bit finder over the 6-bit remaining mask. Outputs the index and an "any" bit; the FSM uses it for both the first and the next lane.

Test Plan:
- Mask 6'b111111, base 0x10, lanes 0x01..0x06, mem_ready high -> six writes at 0x10..0x15 with data 0x01..0x06 in consecutive cycles; done one cycle later; in_ready the cycle after that.
- Mask 6'b100101, base 0x20 -> writes only at 0x20, 0x22, 0x25 (lanes 0, 2, 5), in that order, no other mem_we cycles.
- Mask 0 -> no mem_we; done pulses in the cycle after capture; busy high for exactly that one cycle.
- Mask 6'b000011, base 0x30, mem_ready low for 3 cycles on lane 0 -> addr 0x30 and its data held stable while stalled; lane 1 at 0x31 presented after the handshake.
- Base 0xFE, mask 6'b111111 -> addresses 0xFE, 0xFF, 0x00, 0x01, 0x02, 0x03 (wrap).
- Reset asserted after the 2nd write of a full-mask vector -> mem_we 0 immediately, no further writes, no done, in_ready 1 after release.
- With ALU_WB_STICKY_FLAGS_EN: lane flags 2'b01 on lane 1 and 2'b10 on lane 4, full mask -> sticky_flags = 2'b11 after DONE, and 0 right after the next capture.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// alu_lane_writeback shared types.
// Lane count, FSM states and lane index type.
package alu_wb_pkg;

    localparam int NLANES = 6;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } wb_state_t;

    typedef logic [2:0] lane_idx_t;

endpackage

// File: rtl/alu_lane_writeback_lane_pick.sv
// Lowest-set-bit finder over the 6-bit lane mask.
// any_o is low when no lane remains.
module lane_pick
    import alu_wb_pkg::*;
(
    input  logic [NLANES-1:0] mask_i,
    output lane_idx_t         idx_o,
    output logic              any_o
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx_o = '0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = lane_idx_t'(i);
            end
        end
    end

    assign any_o = |mask_i;

endmodule

// File: rtl/alu_lane_writeback.sv
// Serialises masked ALU lanes onto a byte-wide memory write port.
// Optional sticky flag capture: ALU_WB_STICKY_FLAGS_EN.
module alu_lane_writeback
    import alu_wb_pkg::*;
#(
    parameter int N = 8,
    parameter int A = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0][N-1:0]        lanes,
    input  logic [5:0][1:0]          lane_flags,
    input  logic [5:0]               lane_mask,
    input  logic [A-1:0]             base_addr,
    output logic                     mem_we,
    output logic [A-1:0]             mem_addr,
    output logic [N-1:0]             mem_wdata,
    input  logic                     mem_ready,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               sticky_flags
);

    wb_state_t        state_q;
    logic [5:0]       mask_q;
    lane_idx_t        cur_q;
    logic [5:0][N-1:0] lanes_q;
    logic [A-1:0]     base_q;
    logic             mem_we_q;
    logic [A-1:0]     mem_addr_q;
    logic [N-1:0]     mem_wdata_q;
    logic             done_q;

    logic             idle;
    logic             hs;
    logic [5:0]       mask_d;
    logic [5:0]       pick_src;
    lane_idx_t        pick_idx;
    logic             pick_any;
    logic [A-1:0]     addr_d;
    logic [N-1:0]     wdata_d;

    assign idle     = (state_q == IDLE);
    assign hs       = mem_we_q & mem_ready;
    assign mask_d   = mask_q & ~(6'b000001 << cur_q);
    // In IDLE pick the first lane of the offered mask, else the next one.
    assign pick_src = idle ? lane_mask : mask_d;
    assign addr_d   = (idle ? base_addr : base_q) + A'(pick_idx);
    assign wdata_d  = idle ? lanes[pick_idx] : lanes_q[pick_idx];

    lane_pick u_pick (
        .mask_i (pick_src),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

`ifdef ALU_WB_STICKY_FLAGS_EN
    logic [5:0][1:0] flags_q;
    logic [1:0]      sticky_q;

    // Sticky flags: cleared on capture, accumulate on each write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q  <= '0;
            sticky_q <= '0;
        end else if (idle && in_valid) begin
            flags_q  <= lane_flags;
            sticky_q <= '0;
        end else if (state_q == SEND && hs) begin
            sticky_q <= sticky_q | flags_q[cur_q];
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_flags;
    assign unused_flags = ^lane_flags;
    assign sticky_flags = 2'b00;
`endif

    // Capture, lane-by-lane write sequencing and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            cur_q       <= '0;
            lanes_q     <= '0;
            base_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        lanes_q <= lanes;
                        base_q  <= base_addr;
                        mask_q  <= lane_mask;
                        cur_q   <= pick_idx;
                        if (pick_any) begin
                            state_q     <= SEND;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= wdata_d;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (hs) begin
                        mask_q <= mask_d;
                        if (pick_any) begin
                            cur_q       <= pick_idx;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= wdata_d;
                        end else begin
                            state_q  <= DONE;
                            mem_we_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = idle;
    assign busy      = ~idle;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_lane_writeback.sv
// Randomised and directed bench for alu_lane_writeback.
// Reference: ascending list of (base+i, lane[i]) for each set mask bit.
module tb_alu_lane_writeback;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [5:0][7:0] lanes;
    logic [5:0][1:0] lane_flags;
    logic [5:0]      lane_mask;
    logic [7:0]      base_addr;
    logic            mem_we;
    logic [7:0]      mem_addr;
    logic [7:0]      mem_wdata;
    logic            mem_ready;
    logic            busy;
    logic            done;
    logic [1:0]      sticky_flags;

    int checks = 0;
    int failures = 0;

    alu_lane_writeback #(.N(8), .A(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .lanes        (lanes),
        .lane_flags   (lane_flags),
        .lane_mask    (lane_mask),
        .base_addr    (base_addr),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .done         (done),
        .sticky_flags (sticky_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sticky_exp(input logic [1:0] v);
`ifdef ALU_WB_STICKY_FLAGS_EN
        return v;
`else
        return 2'b00 & v;
`endif
    endfunction

    // mode 0: ready always high, 1: random ready, 2: first 3 offers stalled
    task automatic run_vec(input logic [5:0] m, input logic [7:0] b,
                           input logic [5:0][7:0] lv,
                           input logic [5:0][1:0] fl,
                           input int mode, input string tag);
        logic [15:0] q[$];
        logic [1:0]  sx;
        int          pop;
        int          n;
        int          stall;
        bit          fin;
        sx  = 2'b00;
        pop = 0;
        for (int i = 0; i < 6; i++) begin
            if (m[i]) begin
                q.push_back({b + 8'(i), lv[i]});
                sx |= fl[i];
                pop++;
            end
        end
        @(posedge clk); #1;
        in_valid   = 1'b1;
        lane_mask  = m;
        base_addr  = b;
        lanes      = lv;
        lane_flags = fl;
        chk({tag, ":in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        lane_mask  = 6'($urandom);
        base_addr  = 8'($urandom);
        lanes      = {$urandom, $urandom};
        lane_flags = 12'($urandom);
        n     = 1;
        stall = 0;
        fin   = 1'b0;
        while (!fin) begin
            case (mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = 1'($urandom_range(0, 1));
                default: mem_ready = (stall >= 3);
            endcase
            if (mem_we && !mem_ready) stall++;
            if (n == 1) chk({tag, ":sticky_clr"}, sticky_flags, 0);
            chk({tag, ":busy"}, busy, 1);
            if (mode == 0) chk({tag, ":we_cycle"}, mem_we, 32'(n <= pop));
            if (mem_we) begin
                if (q.size() == 0) begin
                    chk({tag, ":extra_we"}, mem_we, 0);
                end else begin
                    chk({tag, ":addr"}, mem_addr, q[0][15:8]);
                    chk({tag, ":data"}, mem_wdata, q[0][7:0]);
                    if (mem_ready) void'(q.pop_front());
                end
            end
            if (done) begin
                chk({tag, ":left"}, q.size(), 0);
                chk({tag, ":we_at_done"}, mem_we, 0);
                chk({tag, ":in_ready_done"}, in_ready, 0);
                if (mode == 0) chk({tag, ":done_cycle"}, n, pop + 1);
                chk({tag, ":sticky"}, sticky_flags, sticky_exp(sx));
                fin = 1'b1;
            end else begin
                n++;
                if (n > 300) begin
                    chk({tag, ":timeout"}, done, 1);
                    fin = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ":done_drop"}, done, 0);
        chk({tag, ":idle_busy"}, busy, 0);
        chk({tag, ":idle_ready"}, in_ready, 1);
        chk({tag, ":sticky_hold"}, sticky_flags, sticky_exp(sx));
    endtask

    initial begin
        logic [5:0][7:0] lv;
        logic [5:0][1:0] fl;
        reset      = 1'b1;
        in_valid   = 1'b0;
        lanes      = '0;
        lane_flags = '0;
        lane_mask  = '0;
        base_addr  = '0;
        mem_ready  = 1'b1;
        #1;
        chk("rst:we", mem_we, 0);
        chk("rst:addr", mem_addr, 0);
        chk("rst:wdata", mem_wdata, 0);
        chk("rst:done", done, 0);
        chk("rst:busy", busy, 0);
        chk("rst:sticky", sticky_flags, 0);
        chk("rst:in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        lv = {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        fl = '0;
        run_vec(6'b111111, 8'h10, lv, fl, 0, "full");
        run_vec(6'b100101, 8'h20, lv, fl, 0, "sparse");
        run_vec(6'b000000, 8'h44, lv, fl, 0, "empty");
        lv = {8'h66, 8'h55, 8'h44, 8'h33, 8'hB2, 8'hA1};
        run_vec(6'b000011, 8'h30, lv, fl, 2, "stall");
        run_vec(6'b111111, 8'hFE, lv, fl, 0, "wrap");
        fl = {2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
        run_vec(6'b111111, 8'h50, lv, fl, 0, "flags");
        fl = '0;
        run_vec(6'b000100, 8'h60, lv, fl, 1, "after_flags");

        // Reset in the middle of a full-mask transfer.
        @(posedge clk); #1;
        in_valid  = 1'b1;
        lane_mask = 6'b111111;
        base_addr = 8'h40;
        lanes     = lv;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort:w1", mem_we, 1);
        @(posedge clk); #1;
        chk("abort:w2_addr", mem_addr, 8'h41);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort:we", mem_we, 0);
        chk("abort:busy", busy, 0);
        chk("abort:done", done, 0);
        chk("abort:in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("abort:no_we", mem_we, 0);
            chk("abort:no_done", done, 0);
            chk("abort:ready", in_ready, 1);
        end

        for (int r = 0; r < 25; r++) begin
            lv = {$urandom, $urandom};
            fl = 12'($urandom);
            run_vec(6'($urandom), 8'($urandom), lv, fl,
                    int'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
